// File: rtl/reset_sequencer.sv
// Staged reset-release controller: holds all domains in reset, then releases them one at a
// time, waiting for each domain's ack; timeouts and software requests restart the sequence.
module reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned STAGE_DELAY = 16,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  seq_done,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int unsigned MaxHd  = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
  localparam int unsigned MaxAll = (MaxHd > ACK_TIMEOUT) ? MaxHd : ACK_TIMEOUT;
  localparam int unsigned CntW   = $clog2(MaxAll + 1);
  localparam int unsigned IdxW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef enum logic [1:0] {
    StHold,
    StGap,
    StWaitAck,
    StDone
  } state_e;

  state_e                r_state, w_state_d;
  logic [CntW-1:0]       r_cnt, w_cnt_d;
  logic [IdxW-1:0]       r_idx, w_idx_d;
  logic [NUM_STAGES-1:0] r_rst_out, w_rst_out_d;
  logic                  r_done, w_done_d;
  logic                  r_busy;
  logic                  r_tmo, w_tmo_d;
  logic                  w_ack;
  logic                  w_last;

  assign w_ack  = stage_ack[r_idx];
  assign w_last = (r_idx == IdxW'(NUM_STAGES - 1));

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt + 1'b1;
    w_idx_d     = r_idx;
    w_rst_out_d = r_rst_out;
    w_done_d    = r_done;
    w_tmo_d     = r_tmo;
    if (sw_rst_req) begin
      // Restart from any state; the sticky timeout flag survives.
      w_state_d   = StHold;
      w_cnt_d     = '0;
      w_idx_d     = '0;
      w_rst_out_d = '1;
      w_done_d    = 1'b0;
    end else begin
      unique case (r_state)
        StHold: begin
          if (r_cnt == CntW'(HOLD_CYCLES - 1)) begin
            w_state_d = StGap;
            w_cnt_d   = '0;
            w_idx_d   = '0;
          end
        end
        StGap: begin
          if (r_cnt == CntW'(STAGE_DELAY - 1)) begin
            w_state_d          = StWaitAck;
            w_cnt_d            = '0;
            w_rst_out_d[r_idx] = 1'b0;
          end
        end
        StWaitAck: begin
          // An ack in the final timeout cycle wins over the timeout.
          if (w_ack) begin
            w_cnt_d = '0;
            if (w_last) begin
              w_state_d = StDone;
              w_done_d  = 1'b1;
            end else begin
              w_state_d = StGap;
              w_idx_d   = r_idx + 1'b1;
            end
          end else if (r_cnt == CntW'(ACK_TIMEOUT - 1)) begin
            w_state_d   = StHold;
            w_cnt_d     = '0;
            w_idx_d     = '0;
            w_rst_out_d = '1;
            w_tmo_d     = 1'b1;
          end
        end
        StDone: begin
          w_cnt_d = r_cnt;
        end
        default: begin
          w_state_d   = StHold;
          w_cnt_d     = '0;
          w_idx_d     = '0;
          w_rst_out_d = '1;
          w_done_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StHold;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rst_out <= '1;
      r_done    <= 1'b0;
      r_busy    <= 1'b1;
      r_tmo     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_idx     <= w_idx_d;
      r_rst_out <= w_rst_out_d;
      r_done    <= w_done_d;
      r_busy    <= ~w_done_d;
      r_tmo     <= w_tmo_d;
    end
  end

  assign rst_out     = r_rst_out;
  assign seq_done    = r_done;
  assign busy        = r_busy;
  assign timeout_err = r_tmo;

endmodule
